product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream consumer of the shift-add MULTIPLIER product. It sums a programmed number
//  of unsigned (m+n)-bit products into an ACC_W-bit accumulator, forming a dot product.
//  The accumulator saturates on overflow and raises a sticky overflow flag.
//  The final sum is presented on a valid/ready output handshake to the next stage.
// PARAMETERS
//  m      8   multiplicand width, as for MULTIPLIER
//  n      8   multiplier width, as for MULTIPLIER
//  ACC_W  18  accumulator/result width; must be >= m+n
//  LEN_W  4   width of the term-count input (max 2**LEN_W-1 terms)
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      asynchronous reset, active-high
//  start      input   1      begin new accumulation; sampled only in IDLE
//  len        input   LEN_W  number of products to accumulate; latched with start
//  prod_in    input   m+n    unsigned product from the multiplier
//  prod_valid input   1      prod_in is valid this cycle
//  prod_ready output  1      block accepts a product this cycle
//  sum_out    output  ACC_W  registered accumulated result
//  sum_valid  output  1      sum_out is valid; held until sum_ready
//  sum_ready  input   1      downstream accepts sum_out
//  busy       output  1      1 whenever state != IDLE
//  ovf        output  1      sticky saturation flag for the current/last operation
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; acc=0, cnt=0.
//   - sum_out=0, sum_valid=0, ovf=0; busy=0 and prod_ready=0 immediately.
//   - Any operation in flight is abandoned with no output.
//  FSM states: IDLE, ACC, DONE.
//  IDLE:
//   - start=1, len!=0 -> ACC; acc<=0, cnt<=len, ovf<=0.
//   - start=1, len==0 -> DONE; sum_out<=0, sum_valid<=1, ovf<=0.
//   - start=0 -> stay in IDLE.
//  ACC:
//   - prod_ready=1 (combinational decode of state).
//   - Accept on prod_valid&&prod_ready: s = acc + zero-extended prod_in, computed ACC_W+1 wide.
//   - If s[ACC_W]=1 or acc is already saturated: acc<=all ones, ovf<=1. Otherwise acc<=s[ACC_W-1:0].
//   - On accept, cnt<=cnt-1.
//   - Accept with cnt==1 -> DONE; sum_out<=new acc value, sum_valid<=1.
//   - Latency: sum_valid rises on the edge that accepts the last product; visible the next cycle.
//   - prod_valid=0 -> hold all state; there is no timeout.
//  DONE:
//   - prod_ready=0; sum_out and sum_valid held stable.
//   - sum_valid&&sum_ready -> IDLE; sum_valid=0 from the following cycle.
//   - sum_out retains its value in IDLE until the next result is written.
//  Simultaneous/ignored events:
//   - start outside IDLE is ignored; len is sampled only with start in IDLE.
//   - prod_valid in IDLE or DONE is dropped and does not change acc or cnt.
//   - Handshake completing in DONE with start=1 in the same cycle: start ignored; next start is taken from IDLE.
//  Width rule: products are zero-extended, never truncated. Saturation value = 2**ACC_W-1.
// TESTING
//  1. len=3, prod 10,20,30 back-to-back -> sum_out=60, sum_valid 1 cycle after 3rd accept, ovf=0.
//  2. len=2, gaps of 3 idle cycles between prod_valid pulses, prod 5,9 -> sum_out=14; acc unchanged during gaps.
//  3. sum_ready=0 for 5 cycles in DONE -> sum_valid=1 and sum_out stable; prod_ready=0; start pulse ignored, busy=1.
//  4. len=5, each prod 65025 (ACC_W=18) -> sum_out=262143, ovf=1; next start with len=1, prod 3 -> sum_out=3, ovf=0.
//  5. len=0 start -> sum_valid=1, sum_out=0 next cycle; a concurrent prod_valid is not accepted.
//  6. rst asserted after 2 of 4 products -> outputs zero asynchronously, busy=0; then len=1, prod 7 -> sum_out=7.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a programmed number of unsigned multiplier products into a saturating
// accumulator (a dot product). The result is handed to the next stage over a
// valid/ready handshake. A sticky flag records saturation for the current or
// most recent operation.
module product_accumulator #(
  parameter int m     = 8,
  parameter int n     = 8,
  parameter int ACC_W = 18,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [m+n-1:0]     prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   sum_out,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               busy,
  output logic               ovf
);

  // Product width and the zero padding that widens a product to the
  // (ACC_W+1)-bit adder. Products are never truncated, so the pad is at
  // least one bit wide.
  localparam int PROD_W = m + n;
  localparam int PAD_W  = ACC_W + 1 - PROD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturating add. Bit ACC_W of the return value is the saturation event,
  // the lower bits are the new accumulator value. An accumulator that is
  // already pinned at full scale stays there and keeps reporting saturation.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0]  acc_val,
    input logic [PROD_W-1:0] prod_val
  );
    logic [ACC_W:0] wide_sum;
    wide_sum = {1'b0, acc_val} + {{PAD_W{1'b0}}, prod_val};
    if (wide_sum[ACC_W] || (&acc_val)) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = {1'b0, wide_sum[ACC_W-1:0]};
    end
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_s;
  logic [LEN_W-1:0]   cnt_r;
  logic [LEN_W-1:0]   cnt_s;
  logic [ACC_W-1:0]   sum_r;
  logic [ACC_W-1:0]   sum_s;
  logic               sum_valid_r;
  logic               sum_valid_s;
  logic               ovf_r;
  logic               ovf_s;

  logic               accept_s;
  logic               last_term_s;
  logic               start_empty_s;
  logic [ACC_W:0]     add_s;
  logic               add_sat_s;
  logic [ACC_W-1:0]   add_val_s;
  logic               busy_s;
  logic               prod_ready_s;

  // Decode of the current state into the product-side handshake and busy.
  always_comb begin
    busy_s       = 1'b0;
    prod_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s       = 1'b0;
        prod_ready_s = 1'b0;
      end
      ST_ACC: begin
        busy_s       = 1'b1;
        prod_ready_s = 1'b1;
      end
      ST_DONE: begin
        busy_s       = 1'b1;
        prod_ready_s = 1'b0;
      end
      default: begin
        busy_s       = 1'b1;
        prod_ready_s = 1'b0;
      end
    endcase
  end

  // Datapath helpers: product acceptance, last-term detect and saturating sum.
  always_comb begin
    accept_s      = prod_valid && prod_ready_s;
    last_term_s   = (cnt_r == LEN_W'(1));
    start_empty_s = (len == {LEN_W{1'b0}});
    add_s         = sat_add(acc_r, prod_in);
    add_sat_s     = add_s[ACC_W];
    add_val_s     = add_s[ACC_W-1:0];
  end

  // Next-state and next-register decode; every register holds by default.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    sum_s       = sum_r;
    sum_valid_s = sum_valid_r;
    ovf_s       = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ovf_s = 1'b0;
          if (start_empty_s) begin
            // Zero-length dot product: report an empty sum straight away.
            state_s     = ST_DONE;
            sum_s       = {ACC_W{1'b0}};
            sum_valid_s = 1'b1;
          end else begin
            state_s = ST_ACC;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = len;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (accept_s) begin
          acc_s = add_val_s;
          cnt_s = cnt_r - LEN_W'(1);
          if (add_sat_s) begin
            ovf_s = 1'b1;
          end else begin
            ovf_s = ovf_r;
          end
          if (last_term_s) begin
            // Result is published on the same edge that takes the last term.
            state_s     = ST_DONE;
            sum_s       = add_val_s;
            sum_valid_s = 1'b1;
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          // No timeout: wait as long as the producer needs.
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (sum_valid_r && sum_ready) begin
          // A start seen here is deliberately ignored; it must be
          // re-presented once the block is back in IDLE.
          state_s     = ST_IDLE;
          sum_valid_s = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE without emitting a result.
        state_s     = ST_IDLE;
        sum_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      sum_r       <= {ACC_W{1'b0}};
      sum_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      sum_r       <= sum_s;
      sum_valid_r <= sum_valid_s;
      ovf_r       <= ovf_s;
    end
  end

  assign sum_out    = sum_r;
  assign sum_valid  = sum_valid_r;
  assign ovf        = ovf_r;
  assign busy       = busy_s;
  assign prod_ready = prod_ready_s;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed stimulus with hand-computed expected sums. Expected results are
// queued when an operation is started; a monitor pops and compares each time
// the DUT completes an output handshake.
module tb_product_accumulator;

  localparam int M     = 8;
  localparam int N     = 8;
  localparam int ACC_W = 18;
  localparam int LEN_W = 4;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic [M+N-1:0]     prod_in;
  logic               prod_valid;
  logic               prod_ready;
  logic [ACC_W-1:0]   sum_out;
  logic               sum_valid;
  logic               sum_ready;
  logic               busy;
  logic               ovf;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  product_accumulator #(.m(M), .n(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_sum(input int unsigned s, input logic o);
    exp_t e;
    e.sum = ACC_W'(s);
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input int unsigned l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input int unsigned v);
    int k;
    k = 0;
    prod_valid = 1'b1;
    prod_in    = (M+N)'(v);
    while (!prod_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("prod_ready_before_accept", 32'(prod_ready), 32'd1);
    if (prod_ready) begin
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  // Monitor: every completed output handshake is scored against the queue.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sum_out", 32'(sum_out), 32'(mon_e.sum));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    sum_ready  = 1'b1;
    #1;
    check("rst_sum_out", 32'(sum_out), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prod_ready", 32'(prod_ready), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: three back-to-back products.
    expect_sum(60, 1'b0);
    do_start(3);
    check("t1_busy", 32'(busy), 32'd1);
    push(10);
    push(20);
    check("t1_no_early_valid", 32'(sum_valid), 32'd0);
    push(30);
    check("t1_valid_latency", 32'(sum_valid), 32'd1);
    check("t1_sum_direct", 32'(sum_out), 32'd60);
    wait_idle();

    // 2: idle gaps between products leave the accumulator untouched.
    expect_sum(14, 1'b0);
    do_start(2);
    push(5);
    for (int i = 0; i < 3; i++) begin
      check("t2_acc_hold", 32'(dut.acc_r), 32'd5);
      check("t2_cnt_hold", 32'(dut.cnt_r), 32'd1);
      check("t2_no_valid", 32'(sum_valid), 32'd0);
      @(posedge clk); #1;
    end
    push(9);
    wait_idle();

    // 3: back-pressure in DONE, ignored start, handshake with start.
    sum_ready = 1'b0;
    expect_sum(42, 1'b0);
    do_start(1);
    push(42);
    for (int i = 0; i < 5; i++) begin
      check("t3_valid_held", 32'(sum_valid), 32'd1);
      check("t3_sum_held", 32'(sum_out), 32'd42);
      check("t3_prod_ready_low", 32'(prod_ready), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      if (i == 2) begin
        start = 1'b1;
        len   = LEN_W'(2);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start     = 1'b1;
    len       = LEN_W'(3);
    sum_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t3_start_ignored_busy", 32'(busy), 32'd0);
    check("t3_valid_dropped", 32'(sum_valid), 32'd0);
    check("t3_sum_retained", 32'(sum_out), 32'd42);

    // 5: zero-length operation with a concurrent product that must be dropped.
    expect_sum(0, 1'b0);
    prod_valid = 1'b1;
    prod_in    = 16'd99;
    do_start(0);
    check("t5_valid", 32'(sum_valid), 32'd1);
    check("t5_sum_zero", 32'(sum_out), 32'd0);
    check("t5_prod_ready_low", 32'(prod_ready), 32'd0);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    check("t5_acc_untouched", 32'(dut.acc_r), 32'd42);
    check("t5_cnt_untouched", 32'(dut.cnt_r), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // 4: saturation, then ovf clears on the next start.
    expect_sum(262143, 1'b1);
    do_start(5);
    check("t4_ovf_start", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      push(65025);
    end
    check("t4_ovf_direct", 32'(ovf), 32'd1);
    check("t4_sat_direct", 32'(sum_out), 32'd262143);
    wait_idle();
    expect_sum(3, 1'b0);
    do_start(1);
    check("t4_ovf_cleared", 32'(ovf), 32'd0);
    push(3);
    wait_idle();

    // 6: asynchronous reset mid-operation abandons the result.
    do_start(4);
    push(1);
    push(2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_sum_out", 32'(sum_out), 32'd0);
    check("t6_rst_sum_valid", 32'(sum_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_prod_ready", 32'(prod_ready), 32'd0);
    check("t6_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_sum(7, 1'b0);
    do_start(1);
    push(7);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
